nios2e_nios2_qsys_0_ocimem_ctrl: RTL and testbench

NIOS2E_NIOS2_QSYS_0_OCIMEM_CTRL -- requirements
Module: nios2e_nios2_qsys_0_ocimem_ctrl

---
 rtl/nios2e_nios2_qsys_0_ocimem_ctrl_if.sv | 29 ++
 rtl/nios2e_nios2_qsys_0_ocimem_ctrl.sv | 125 ++++++++++++
 tb/tb_nios2e_nios2_qsys_0_ocimem_ctrl.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/nios2e_nios2_qsys_0_ocimem_ctrl_if.sv
// CPU slave bus and JTAG sysclk-side command/monitor signals of the OCI debug RAM.
interface nios2e_nios2_qsys_0_ocimem_ctrl_if #(
  parameter int unsigned AW = 8
);
  logic [37:0]   jdo;
  logic          take_action_ocimem_a;
  logic          take_no_action_ocimem_a;
  logic          take_action_ocimem_b;
  logic [AW-1:0] cpu_address;
  logic          cpu_read;
  logic          cpu_write;
  logic [31:0]   cpu_writedata;
  logic [31:0]   cpu_readdata;
  logic          cpu_waitrequest;
  logic [31:0]   MonDReg;
  logic          jtag_busy;

  modport master (
    output jdo, take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b,
    output cpu_address, cpu_read, cpu_write, cpu_writedata,
    input  cpu_readdata, cpu_waitrequest, MonDReg, jtag_busy
  );

  modport slave (
    input  jdo, take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b,
    input  cpu_address, cpu_read, cpu_write, cpu_writedata,
    output cpu_readdata, cpu_waitrequest, MonDReg, jtag_busy
  );
endinterface

// File: rtl/nios2e_nios2_qsys_0_ocimem_ctrl.sv
// OCI debug RAM controller: single-port RAM shared between the CPU slave port
// and one-entry JTAG read/write commands that feed the MonDReg monitor register.
module nios2e_nios2_qsys_0_ocimem_ctrl #(
  parameter int unsigned RAM_DEPTH = 256
) (
  input logic clk,
  input logic reset,
  nios2e_nios2_qsys_0_ocimem_ctrl_if.slave bus
);
  localparam int unsigned AW = $clog2(RAM_DEPTH);
  localparam int unsigned DW = 32;

  typedef enum logic [1:0] {IDLE, JGRANT, JRD_WAIT, JRD_CAP} state_t;

  state_t        r_state, w_next;
  logic          r_pend_valid, r_pend_wr;
  logic [DW-1:0] r_pend_data;
  logic [AW-1:0] r_jaddr;
  logic [DW-1:0] r_mon, r_ram_q, r_rd_hold;
  logic          r_rd_sel;
  logic [DW-1:0] r_mem [RAM_DEPTH];

  logic          w_strobe, w_busy, w_strobe_acc, w_load_addr;
  logic          w_cpu_req, w_wait, w_cpu_acc, w_cpu_wr_acc, w_cpu_rd_acc;
  logic          w_jwr, w_cap, w_ram_we;
  logic [AW-1:0] w_ram_addr;
  logic [DW-1:0] w_ram_wdata;
  logic          w_unused_jdo;

  assign w_strobe     = bus.take_action_ocimem_b | bus.take_action_ocimem_a |
                        bus.take_no_action_ocimem_a;
  assign w_busy       = r_pend_valid | (r_state != IDLE);
  assign w_strobe_acc = w_strobe & ~w_busy;
  assign w_load_addr  = w_strobe_acc & ~bus.take_action_ocimem_b &
                        bus.take_action_ocimem_a & bus.jdo[17];

  // A new strobe never stalls the CPU; only a command already latched does.
  assign w_cpu_req    = bus.cpu_read | bus.cpu_write;
  assign w_wait       = w_cpu_req & w_busy;
  assign w_cpu_acc    = w_cpu_req & ~w_wait;
  assign w_cpu_wr_acc = w_cpu_acc & bus.cpu_write;
  assign w_cpu_rd_acc = w_cpu_acc & bus.cpu_read & ~bus.cpu_write;

  // JTAG keeps the RAM address through JRD_WAIT so the captured word stays stable.
  assign w_ram_addr  = ((r_state == JGRANT) || (r_state == JRD_WAIT)) ? r_jaddr
                                                                     : AW'(bus.cpu_address);
  assign w_ram_we    = ~reset & (w_jwr | w_cpu_wr_acc);
  assign w_ram_wdata = w_jwr ? r_pend_data : bus.cpu_writedata;

  assign w_unused_jdo = ^{bus.jdo[37:35], bus.jdo[2:0]};

  always_comb begin
    w_next = r_state;
    w_jwr  = 1'b0;
    w_cap  = 1'b0;
    unique case (r_state)
      IDLE:     if (w_strobe_acc || r_pend_valid) w_next = JGRANT;
      JGRANT: begin
        if (r_pend_wr) begin
          w_jwr  = 1'b1;
          w_next = IDLE;
        end else begin
          w_next = JRD_WAIT;
        end
      end
      JRD_WAIT: w_next = JRD_CAP;
      JRD_CAP: begin
        w_cap  = 1'b1;
        w_next = IDLE;
      end
      default:  w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend_valid <= 1'b0;
      r_pend_wr    <= 1'b0;
      r_pend_data  <= '0;
    end else if (w_strobe_acc) begin
      r_pend_valid <= 1'b1;
      r_pend_wr    <= bus.take_action_ocimem_b;
      r_pend_data  <= bus.jdo[34:3];
    end else if (w_jwr || w_cap) begin
      r_pend_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                r_jaddr <= '0;
    else if (w_load_addr)     r_jaddr <= AW'(bus.jdo[33:26]);
    else if (w_jwr || w_cap)  r_jaddr <= r_jaddr + AW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset)      r_mon <= '0;
    else if (w_cap) r_mon <= r_ram_q;
  end

  // RAM contents and its output register are deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_ram_we) r_mem[w_ram_addr] <= w_ram_wdata;
    r_ram_q <= r_mem[w_ram_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_sel  <= 1'b0;
      r_rd_hold <= '0;
    end else begin
      r_rd_sel <= w_cpu_rd_acc;
      if (r_rd_sel) r_rd_hold <= r_ram_q;
    end
  end

  assign bus.cpu_readdata    = r_rd_sel ? r_ram_q : r_rd_hold;
  assign bus.cpu_waitrequest = w_wait;
  assign bus.MonDReg         = r_mon;
  assign bus.jtag_busy       = w_busy;
endmodule

// File: tb/tb_nios2e_nios2_qsys_0_ocimem_ctrl.sv
// Directed bench for the OCI debug RAM controller with a RAM/jaddr model and
// an expected-value queue.
module tb_nios2e_nios2_qsys_0_ocimem_ctrl;
  localparam int unsigned AW    = 8;
  localparam int unsigned DEPTH = 256;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  nios2e_nios2_qsys_0_ocimem_ctrl_if #(.AW(AW)) bus ();
  nios2e_nios2_qsys_0_ocimem_ctrl #(.RAM_DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));

  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_mem [DEPTH];
  logic [7:0]  m_jaddr;
  logic [31:0] m_mon;
  logic [31:0] q_exp [$];

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pat(input int i);
    logic [7:0] b;
    b = 8'(i);
    return {8'hA5, b, ~b, b};
  endfunction

  function automatic logic [37:0] jdo_a(input logic ld, input logic [7:0] addr);
    logic [37:0] r;
    r = '0;
    r[17] = ld;
    r[33:26] = addr;
    return r;
  endfunction

  function automatic logic [37:0] jdo_b(input logic [31:0] data);
    logic [37:0] r;
    r = '0;
    r[34:3] = data;
    return r;
  endfunction

  // Strobe held for exactly one cycle; returns one tick later.
  task automatic strobe(input logic a, input logic na, input logic b, input logic [37:0] d);
    bus.jdo = d;
    bus.take_action_ocimem_a = a;
    bus.take_no_action_ocimem_a = na;
    bus.take_action_ocimem_b = b;
    tick();
    bus.take_action_ocimem_a = 1'b0;
    bus.take_no_action_ocimem_a = 1'b0;
    bus.take_action_ocimem_b = 1'b0;
  endtask

  task automatic jtag_read(input string tag, input logic ld, input logic [7:0] addr, input logic na);
    if (ld) m_jaddr = addr;
    q_exp.push_back(m_mem[m_jaddr]);
    m_jaddr++;
    strobe(~na, na, 1'b0, jdo_a(ld, addr));
    chk({tag, "_busy"}, 32'(bus.jtag_busy), 32'd1);
    tick();
    tick();
    chk({tag, "_early"}, bus.MonDReg, m_mon);
    tick();
    m_mon = q_exp.pop_front();
    chk(tag, bus.MonDReg, m_mon);
    chk({tag, "_idle"}, 32'(bus.jtag_busy), 32'd0);
    tick();
  endtask

  task automatic jtag_write(input string tag, input logic [31:0] data, input logic na_too);
    m_mem[m_jaddr] = data;
    m_jaddr++;
    strobe(1'b0, na_too, 1'b1, jdo_b(data));
    chk({tag, "_busy"}, 32'(bus.jtag_busy), 32'd1);
    tick();
    tick();
    tick();
    chk({tag, "_mon"}, bus.MonDReg, m_mon);
    chk({tag, "_idle"}, 32'(bus.jtag_busy), 32'd0);
  endtask

  task automatic cpu_wr(input logic [7:0] addr, input logic [31:0] data, input logic do_chk);
    bus.cpu_address = addr;
    bus.cpu_writedata = data;
    bus.cpu_write = 1'b1;
    #1;
    if (do_chk) chk("cpu_wr_wait", 32'(bus.cpu_waitrequest), 32'd0);
    tick();
    bus.cpu_write = 1'b0;
    m_mem[addr] = data;
  endtask

  task automatic cpu_rd(input string tag, input logic [7:0] addr);
    bus.cpu_address = addr;
    bus.cpu_read = 1'b1;
    #1;
    chk({tag, "_wait"}, 32'(bus.cpu_waitrequest), 32'd0);
    q_exp.push_back(m_mem[addr]);
    tick();
    bus.cpu_read = 1'b0;
    chk(tag, bus.cpu_readdata, q_exp.pop_front());
  endtask

  initial begin
    reset = 1'b1;
    bus.jdo = '0;
    bus.take_action_ocimem_a = 1'b0;
    bus.take_no_action_ocimem_a = 1'b0;
    bus.take_action_ocimem_b = 1'b0;
    bus.cpu_address = '0;
    bus.cpu_read = 1'b0;
    bus.cpu_write = 1'b0;
    bus.cpu_writedata = '0;
    m_jaddr = 8'h00;
    m_mon = 32'h0;

    // Strobe coincident with reset must be ignored.
    bus.jdo = jdo_b(32'h12345678);
    bus.take_action_ocimem_b = 1'b1;
    tick();
    tick();
    bus.take_action_ocimem_b = 1'b0;
    reset = 1'b0;
    chk("rst_mon", bus.MonDReg, 32'h0);
    chk("rst_rdata", bus.cpu_readdata, 32'h0);
    chk("rst_busy", 32'(bus.jtag_busy), 32'd0);
    chk("rst_wait", 32'(bus.cpu_waitrequest), 32'd0);
    tick();
    chk("rst_strobe_ignored", 32'(bus.jtag_busy), 32'd0);

    for (int i = 0; i < int'(DEPTH); i++) cpu_wr(8'(i), pat(i), 1'b0);
    cpu_rd("cpu_rd00", 8'h00);
    cpu_rd("cpu_rd7f", 8'h7F);
    cpu_rd("cpu_rdff", 8'hFF);
    tick();
    chk("cpu_rd_hold", bus.cpu_readdata, m_mem[8'hFF]);

    // Load, write, reload, then confirm jaddr post-increment.
    jtag_read("j_ld10", 1'b1, 8'h10, 1'b0);
    jtag_write("j_wr11", 32'hDEADBEEF, 1'b0);
    jtag_read("j_ld11", 1'b1, 8'h11, 1'b0);
    jtag_read("j_na12", 1'b0, 8'h00, 1'b1);
    cpu_rd("j_cpu11", 8'h11);

    // Address wrap 0xFF -> 0x00.
    jtag_read("w_ldfe", 1'b1, 8'hFE, 1'b0);
    jtag_write("w_ff", 32'h0BADF00D, 1'b0);
    jtag_write("w_00", 32'hCAFEF00D, 1'b0);
    jtag_read("w_na01", 1'b0, 8'h00, 1'b1);
    cpu_rd("w_cpuff", 8'hFF);
    cpu_rd("w_cpu00", 8'h00);

    // Second write strobe while busy is dropped.
    m_mem[m_jaddr] = 32'h11112222;
    m_jaddr++;
    strobe(1'b0, 1'b0, 1'b1, jdo_b(32'h11112222));
    chk("d_busy", 32'(bus.jtag_busy), 32'd1);
    strobe(1'b0, 1'b0, 1'b1, jdo_b(32'h33334444));
    tick();
    tick();
    jtag_read("d_na03", 1'b0, 8'h00, 1'b1);
    cpu_rd("d_cpu02", 8'h02);

    // Simultaneous write and no-action read: only the write runs.
    jtag_write("s_wr04", 32'h55AA55AA, 1'b1);
    jtag_read("s_na05", 1'b0, 8'h00, 1'b1);
    cpu_rd("s_cpu04", 8'h04);

    // CPU write held from the strobe cycle of a JTAG read to the same word.
    bus.cpu_address = 8'h40;
    bus.cpu_writedata = 32'h600DC0DE;
    bus.cpu_write = 1'b1;
    m_mem[8'h40] = 32'h600DC0DE;
    m_jaddr = 8'h41;
    q_exp.push_back(32'h600DC0DE);
    bus.jdo = jdo_a(1'b1, 8'h40);
    bus.take_action_ocimem_a = 1'b1;
    #1;
    chk("c_wait0", 32'(bus.cpu_waitrequest), 32'd0);
    tick();
    bus.take_action_ocimem_a = 1'b0;
    chk("c_wait1", 32'(bus.cpu_waitrequest), 32'd1);
    tick();
    chk("c_wait2", 32'(bus.cpu_waitrequest), 32'd1);
    tick();
    chk("c_wait3", 32'(bus.cpu_waitrequest), 32'd1);
    chk("c_mon_early", bus.MonDReg, m_mon);
    tick();
    chk("c_wait4", 32'(bus.cpu_waitrequest), 32'd0);
    m_mon = q_exp.pop_front();
    chk("c_mon", bus.MonDReg, m_mon);
    bus.cpu_write = 1'b0;
    tick();
    cpu_rd("c_cpu40", 8'h40);

    // Read and write together: write wins, readdata holds.
    bus.cpu_address = 8'h50;
    bus.cpu_writedata = 32'h77778888;
    bus.cpu_read = 1'b1;
    bus.cpu_write = 1'b1;
    tick();
    bus.cpu_read = 1'b0;
    bus.cpu_write = 1'b0;
    m_mem[8'h50] = 32'h77778888;
    chk("rw_hold", bus.cpu_readdata, 32'h600DC0DE);
    cpu_rd("rw_cpu50", 8'h50);

    // Reset during JRD_WAIT aborts the read.
    strobe(1'b1, 1'b0, 1'b0, jdo_a(1'b1, 8'h60));
    tick();
    reset = 1'b1;
    tick();
    chk("r_mon", bus.MonDReg, 32'h0);
    chk("r_busy", 32'(bus.jtag_busy), 32'd0);
    chk("r_rdata", bus.cpu_readdata, 32'h0);
    reset = 1'b0;
    m_mon = 32'h0;
    m_jaddr = 8'h00;
    tick();
    jtag_read("r_na00", 1'b0, 8'h00, 1'b1);
    cpu_rd("r_cpu60", 8'h60);

    // Reset during JGRANT of a write: no RAM write, jaddr back to 0.
    strobe(1'b0, 1'b0, 1'b1, jdo_b(32'hFFFF0000));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_mon = 32'h0;
    m_jaddr = 8'h00;
    tick();
    cpu_rd("rw_cpu01", 8'h01);
    jtag_read("rw_na00", 1'b0, 8'h00, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
